// File: rtl/vga_fb_pkg.sv
// -----------------------------------------------------------------------------
// vga_fb_pkg
// Shared definitions for the VGA image RAM port-A fill engine / arbiter:
// the fill FSM state encoding, frame-buffer geometry and the full-byte
// write mask used for every fill write.
// -----------------------------------------------------------------------------
package vga_fb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  localparam int FB_AW    = 15;
  localparam int FB_DW    = 64;
  localparam int FB_WORDS = 32768;

  // Fill writes always cover the whole 64-bit word.
  localparam logic [7:0] FB_WEN_ALL = 8'hFF;

endpackage

// File: rtl/vga_fb_fill_arb.sv
// -----------------------------------------------------------------------------
// vga_fb_fill_arb
// Shares image RAM port A between CPU bus accesses and a hardware fill engine
// that writes a 64-bit pattern into a contiguous (wrapping) word range.
// The CPU has priority; after STARVE_MAX consecutive fill cycles lost to the
// CPU the fill engine takes one forced cycle, stalling the CPU via cpu_ready.
//
// Ports:
//   cpu_clk, rst_i          clock, asynchronous active-high reset
//   cpu_en/wen/addr/wdata   CPU request (wen = 0 is a read)
//   cpu_rdata               RAM read data passthrough (RAM latency only)
//   cpu_ready               CPU request accepted this cycle
//   fill_start/abort        fill control pulses
//   fill_base/len/pattern   fill range and data, latched on start
//   fill_busy, fill_done    fill in progress / one-cycle completion pulse
//   ram_*                   RAM port A controls and read data
// -----------------------------------------------------------------------------
module vga_fb_fill_arb
  import vga_fb_pkg::*;
#(
  parameter int STARVE_MAX = 15
) (
  input  logic             cpu_clk,
  input  logic             rst_i,
  input  logic             cpu_en,
  input  logic [7:0]       cpu_wen,
  input  logic [FB_AW-1:0] cpu_addr,
  input  logic [FB_DW-1:0] cpu_wdata,
  output logic [FB_DW-1:0] cpu_rdata,
  output logic             cpu_ready,
  input  logic             fill_start,
  input  logic             fill_abort,
  input  logic [FB_AW-1:0] fill_base,
  input  logic [15:0]      fill_len,
  input  logic [FB_DW-1:0] fill_pattern,
  output logic             fill_busy,
  output logic             fill_done,
  output logic             ram_en,
  output logic [7:0]       ram_wen,
  output logic [FB_AW-1:0] ram_addr,
  output logic [FB_DW-1:0] ram_wdata,
  input  logic [FB_DW-1:0] ram_rdata
);

  localparam logic [7:0] STALL_LIM = 8'(STARVE_MAX);

  fill_state_t      state_reg,   state_next;
  logic [FB_AW-1:0] base_reg,    base_next;
  logic [15:0]      len_reg,     len_next;
  logic [FB_DW-1:0] pattern_reg, pattern_next;
  logic [15:0]      offset_reg,  offset_next;
  logic [7:0]       stall_reg,   stall_next;

  logic             forced_fill;
  logic             cpu_gnt;
  logic             fill_gnt;
  logic             last_word;
  logic [FB_AW-1:0] fill_addr;

  // Grant logic
  assign forced_fill = (state_reg == FILL) && (stall_reg == STALL_LIM);
  assign cpu_gnt     = cpu_en && !forced_fill;
  assign fill_gnt    = (state_reg == FILL) && !cpu_gnt;

  // Offset can reach 32767 with len 32768, so the compare needs the full 16 bits.
  assign last_word = ((offset_reg + 16'd1) == len_reg);
  // Truncation to 15 bits gives the wrap past the top of memory to word 0.
  assign fill_addr = base_reg + offset_reg[FB_AW-1:0];

  always_ff @(posedge cpu_clk or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      len_reg     <= '0;
      pattern_reg <= '0;
      offset_reg  <= '0;
      stall_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      len_reg     <= len_next;
      pattern_reg <= pattern_next;
      offset_reg  <= offset_next;
      stall_reg   <= stall_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    len_next     = len_reg;
    pattern_next = pattern_reg;
    offset_next  = offset_reg;
    stall_next   = stall_reg;

    case (state_reg)
      IDLE: begin
        if (fill_start) begin
          base_next    = fill_base;
          len_next     = fill_len;
          pattern_next = fill_pattern;
          offset_next  = '0;
          stall_next   = '0;
          state_next   = (fill_len == 16'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (fill_abort) begin
          state_next = IDLE;
        end else if (fill_gnt) begin
          offset_next = offset_reg + 16'd1;
          stall_next  = '0;
          if (last_word) begin
            state_next = DONE;
          end
        end else if (cpu_gnt) begin
          // Cannot pass STALL_LIM: at the limit the fill is forced instead.
          stall_next = stall_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RAM port mux: CPU when granted, otherwise the fill engine (idle when
  // neither is granted).
  always_comb begin
    ram_en    = cpu_gnt || fill_gnt;
    ram_wen   = 8'h00;
    ram_addr  = fill_addr;
    ram_wdata = pattern_reg;
    if (cpu_gnt) begin
      ram_wen   = cpu_wen;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (fill_gnt) begin
      ram_wen = FB_WEN_ALL;
    end
  end

  assign cpu_ready = !(forced_fill && cpu_en);
  assign cpu_rdata = ram_rdata;
  assign fill_busy = (state_reg == FILL);
  assign fill_done = (state_reg == DONE);

endmodule

// File: tb/tb_vga_fb_fill_arb.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_fill_arb
// Directed bench. Every expected RAM-port transaction is queued when its
// stimulus is issued; a monitor pops and compares on every cycle in which the
// DUT enables the RAM port. Status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_vga_fb_fill_arb;

  typedef struct packed {
    logic [7:0]  wen;
    logic [14:0] addr;
    logic [63:0] data;
  } txn_t;

  logic        cpu_clk;
  logic        rst_i;
  logic        cpu_en;
  logic [7:0]  cpu_wen;
  logic [14:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        cpu_ready;
  logic        fill_start;
  logic        fill_abort;
  logic [14:0] fill_base;
  logic [15:0] fill_len;
  logic [63:0] fill_pattern;
  logic        fill_busy;
  logic        fill_done;
  logic        ram_en;
  logic [7:0]  ram_wen;
  logic [14:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;

  int   total = 0;
  int   bad   = 0;
  txn_t exp_q[$];

  vga_fb_fill_arb #(.STARVE_MAX(15)) dut (
    .cpu_clk     (cpu_clk),
    .rst_i       (rst_i),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .fill_start  (fill_start),
    .fill_abort  (fill_abort),
    .fill_base   (fill_base),
    .fill_len    (fill_len),
    .fill_pattern(fill_pattern),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .ram_en      (ram_en),
    .ram_wen     (ram_wen),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Monitor: one line per RAM-port transaction.
  always @(negedge cpu_clk) begin
    if (!rst_i && ram_en) begin
      txn_t act;
      act   = '{wen: ram_wen, addr: ram_addr, data: ram_wdata};
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL ram_txn: got wen=%h addr=%h data=%h, required none", act.wen, act.addr, act.data);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          bad = bad + 1;
          $display("FAIL ram_txn: got wen=%h addr=%h data=%h, required wen=%h addr=%h data=%h",
                   act.wen, act.addr, act.data, e.wen, e.addr, e.data);
        end else begin
          $display("txn wen=%h addr=%h data=%h ok", act.wen, act.addr, act.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic start_fill(input logic [14:0] b, input logic [15:0] l, input logic [63:0] p);
    fill_base    = b;
    fill_len     = l;
    fill_pattern = p;
    fill_start   = 1'b1;
    tick();
    fill_start   = 1'b0;
  endtask

  task automatic push_fill(input logic [14:0] a, input logic [63:0] p);
    exp_q.push_back('{wen: 8'hFF, addr: a, data: p});
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    int k_exp;
    int k;
    logic rdy;

    rst_i        = 1'b1;
    cpu_en       = 1'b0;
    cpu_wen      = 8'h00;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    fill_start   = 1'b0;
    fill_abort   = 1'b0;
    fill_base    = '0;
    fill_len     = '0;
    fill_pattern = '0;
    ram_rdata    = '0;

    // Reset state
    #3;
    chk("rst_busy", {63'd0, fill_busy}, 64'd0);
    chk("rst_done", {63'd0, fill_done}, 64'd0);
    chk("rst_ready", {63'd0, cpu_ready}, 64'd1);
    chk("rst_ram_en_idle", {63'd0, ram_en}, 64'd0);
    cpu_en = 1'b1;
    #1;
    chk("rst_ram_en_cpu", {63'd0, ram_en}, 64'd1);
    cpu_en = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();

    // Read data passthrough
    ram_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("rdata_a", cpu_rdata, 64'h0123_4567_89AB_CDEF);
    ram_rdata = 64'hFEDC_BA98_7654_3210;
    #1;
    chk("rdata_b", cpu_rdata, 64'hFEDC_BA98_7654_3210);
    tick();

    // Uncontended fill: base 0x0100, len 4
    for (int i = 0; i < 4; i++) push_fill(15'h0100 + 15'(i), 64'hA5A5_A5A5_A5A5_A5A5);
    start_fill(15'h0100, 16'd4, 64'hA5A5_A5A5_A5A5_A5A5);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) chk("unc_busy_first", {63'd0, fill_busy}, 64'd1);
      if (fill_busy) busy_cnt++;
      if (fill_done) begin done_cnt++; done_at = i; end
      tick();
    end
    chk("unc_busy_cycles", 64'(busy_cnt), 64'd4);
    chk("unc_done_count", 64'(done_cnt), 64'd1);
    chk("unc_done_cycle", 64'(done_at), 64'd4);
    chk("unc_queue_drained", 64'(exp_q.size()), 64'd0);

    // Wrap past top of memory
    push_fill(15'h7FFE, 64'h1111_2222_3333_4444);
    push_fill(15'h7FFF, 64'h1111_2222_3333_4444);
    push_fill(15'h0000, 64'h1111_2222_3333_4444);
    push_fill(15'h0001, 64'h1111_2222_3333_4444);
    start_fill(15'h7FFE, 16'd4, 64'h1111_2222_3333_4444);
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_queue_drained", 64'(exp_q.size()), 64'd0);

    // Zero length: done next cycle, never busy, no writes
    start_fill(15'h0500, 16'd0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("zero_done", {63'd0, fill_done}, 64'd1);
    chk("zero_busy", {63'd0, fill_busy}, 64'd0);
    tick();
    chk("zero_done_clear", {63'd0, fill_done}, 64'd0);
    tick();

    // Continuous CPU traffic, len 2: forced fill at cycles 16 and 32
    k_exp = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 16) push_fill(15'h0600, 64'h5555_AAAA_5555_AAAA);
      else if (c == 32) push_fill(15'h0601, 64'h5555_AAAA_5555_AAAA);
      else begin
        exp_q.push_back('{wen: 8'h0F, addr: 15'h1000 + 15'(k_exp), data: {32'hC0DE_0000, 32'(k_exp)}});
        k_exp++;
      end
    end
    start_fill(15'h0600, 16'd2, 64'h5555_AAAA_5555_AAAA);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      cpu_en    = 1'b1;
      cpu_wen   = 8'h0F;
      cpu_addr  = 15'h1000 + 15'(k);
      cpu_wdata = {32'hC0DE_0000, 32'(k)};
      #1;
      chk($sformatf("cont_ready_c%0d", c), {63'd0, cpu_ready}, {63'd0, (c != 16 && c != 32)});
      if (c == 32 || c == 33)
        chk($sformatf("cont_done_c%0d", c), {63'd0, fill_done}, {63'd0, (c == 33)});
      if (c == 32 || c == 33)
        chk($sformatf("cont_busy_c%0d", c), {63'd0, fill_busy}, {63'd0, (c == 32)});
      rdy = cpu_ready;
      tick();
      if (rdy) k++;
    end
    cpu_en  = 1'b0;
    cpu_wen = 8'h00;
    #1;
    chk("cont_queue_drained", 64'(exp_q.size()), 64'd0);
    tick();

    // Abort after 3 of 10 words, then restart immediately
    for (int i = 0; i < 3; i++) push_fill(15'h0200 + 15'(i), 64'h0F0F_0F0F_0F0F_0F0F);
    start_fill(15'h0200, 16'd10, 64'h0F0F_0F0F_0F0F_0F0F);
    tick();
    tick();
    fill_abort = 1'b1;           // third write is on the port this cycle
    tick();
    fill_abort = 1'b0;
    chk("abort_busy", {63'd0, fill_busy}, 64'd0);
    chk("abort_done", {63'd0, fill_done}, 64'd0);
    chk("abort_written", 64'(exp_q.size()), 64'd0);
    push_fill(15'h0300, 64'h7777_7777_7777_7777);
    start_fill(15'h0300, 16'd1, 64'h7777_7777_7777_7777);
    chk("restart_busy", {63'd0, fill_busy}, 64'd1);
    tick();
    chk("restart_done", {63'd0, fill_done}, 64'd1);
    tick();

    // Asynchronous reset mid-fill
    push_fill(15'h0400, 64'h9999_8888_7777_6666);
    push_fill(15'h0401, 64'h9999_8888_7777_6666);
    start_fill(15'h0400, 16'd8, 64'h9999_8888_7777_6666);
    tick();
    @(negedge cpu_clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_busy", {63'd0, fill_busy}, 64'd0);
    chk("arst_ram_en", {63'd0, ram_en}, 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fill_busy || fill_done) chk("arst_idle_after", 64'd1, 64'd0);
      tick();
    end
    chk("arst_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
